// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync/blank/pulse
// decodes, a frame counter and a delay line that realigns sync/blank with a
// registered downstream pixel path.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HActEnd    = 10'(H_ACTIVE);
  localparam logic [9:0] VActEnd    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        act_q, act_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        lstart_q, lstart_d;
  logic        fstart_q, fstart_d;
  logic [15:0] fcount_q, fcount_d;
  logic        x_wrap, frame_wrap;

  // Next-state counters; decodes use the next values so the registered flags
  // line up with the counters they describe on the same cycle.
  always_comb begin
    x_wrap     = (x_q == HLast);
    frame_wrap = x_wrap && (y_q == VLast);
    x_d        = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d        = y_q;
    if (x_wrap) begin
      y_d = (y_q == VLast) ? 10'd0 : y_q + 10'd1;
    end
    act_d    = (x_d < HActEnd) && (y_d < VActEnd);
    hsync_d  = !((x_d >= HSyncStart) && (x_d < HSyncEnd));
    vsync_d  = !((y_d >= VSyncStart) && (y_d < VSyncEnd));
    lstart_d = (x_d == 10'd0);
    fstart_d = (x_d == 10'd0) && (y_d == 10'd0);
    fcount_d = frame_wrap ? fcount_q + 16'd1 : fcount_q;
  end

  // Counter and decoded-flag registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      act_q    <= 1'b1;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
      fcount_q <= 16'd0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      act_q    <= act_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
      fcount_q <= fcount_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = act_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;
  assign frame_count = fcount_q;

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hs_d    = hsync_q;
    assign vs_d    = vsync_q;
    assign blank_d = act_q;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_pipe_q, vs_pipe_q, act_pipe_q;

    // Shift line; stage 0 takes the current registered flags.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe_q  <= '1;
        vs_pipe_q  <= '1;
        act_pipe_q <= '0;
      end else begin
        hs_pipe_q[0]  <= hsync_q;
        vs_pipe_q[0]  <= vsync_q;
        act_pipe_q[0] <= act_q;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          hs_pipe_q[i]  <= hs_pipe_q[i-1];
          vs_pipe_q[i]  <= vs_pipe_q[i-1];
          act_pipe_q[i] <= act_pipe_q[i-1];
        end
      end
    end

    assign hs_d    = hs_pipe_q[PIPE_DELAY-1];
    assign vs_d    = vs_pipe_q[PIPE_DELAY-1];
    assign blank_d = act_pipe_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance (PIPE_DELAY=2) and a
// small-raster instance (PIPE_DELAY=0) so whole frames fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
    logic        hs_d;
    logic        vs_d;
    logic        blank_d;
  } obs_t;

  // Small raster: 15 x 10 = 150 cycles per frame.
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 5, SVF = 1, SVS = 2, SVB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n;
  int   n_total = 0;
  int   n_pass = 0;

  logic [9:0]  d_x, d_y, s_x, s_y;
  logic        d_blank, d_hs, d_vs, d_ls, d_fs, d_hs_d, d_vs_d, d_blank_d;
  logic        s_blank, s_hs, s_vs, s_ls, s_fs, s_hs_d, s_vs_d, s_blank_d;
  logic [15:0] d_fc, s_fc;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
    .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc),
    .hs_d(d_hs_d), .vs_d(d_vs_d), .blank_d(d_blank_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DELAY(0)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc),
    .hs_d(s_hs_d), .vs_d(s_vs_d), .blank_d(s_blank_d)
  );

  // Cycles elapsed since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // Expected outputs n cycles after reset release, from raster arithmetic.
  function automatic obs_t model(input int cyc, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input int p);
    obs_t e;
    int ht, vt, fr, x, y, m, mx, my;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    fr = ht * vt;
    x  = cyc % ht;
    y  = (cyc / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.blank = (x < ha) && (y < va);
    e.hs    = !((x >= ha + hf) && (x < ha + hf + hsw));
    e.vs    = !((y >= va + vf) && (y < va + vf + vsw));
    e.ls    = (cyc > 0) && (x == 0);
    e.fs    = (cyc > 0) && (cyc % fr == 0);
    e.fc    = 16'((cyc / fr) % 65536);
    if (cyc >= p) begin
      m  = cyc - p;
      mx = m % ht;
      my = (m / ht) % vt;
      e.hs_d    = !((mx >= ha + hf) && (mx < ha + hf + hsw));
      e.vs_d    = !((my >= va + vf) && (my < va + vf + vsw));
      e.blank_d = (mx < ha) && (my < va);
    end else begin
      e.hs_d    = 1'b1;
      e.vs_d    = 1'b1;
      e.blank_d = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_all(input string tag, input obs_t a, input obs_t e);
    chk({tag, " DrawX"}, 32'(a.x), 32'(e.x));
    chk({tag, " DrawY"}, 32'(a.y), 32'(e.y));
    chk({tag, " blank"}, 32'(a.blank), 32'(e.blank));
    chk({tag, " hs"}, 32'(a.hs), 32'(e.hs));
    chk({tag, " vs"}, 32'(a.vs), 32'(e.vs));
    chk({tag, " line_start"}, 32'(a.ls), 32'(e.ls));
    chk({tag, " frame_start"}, 32'(a.fs), 32'(e.fs));
    chk({tag, " frame_count"}, 32'(a.fc), 32'(e.fc));
    chk({tag, " hs_d"}, 32'(a.hs_d), 32'(e.hs_d));
    chk({tag, " vs_d"}, 32'(a.vs_d), 32'(e.vs_d));
    chk({tag, " blank_d"}, 32'(a.blank_d), 32'(e.blank_d));
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    cmp_all("dflt", {d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs, d_fc, d_hs_d, d_vs_d, d_blank_d},
            model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    cmp_all("small", {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc, s_hs_d, s_vs_d, s_blank_d},
            model(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 0));
  end

  int hs_low, vs_low, act_cnt;

  initial begin
    hs_low  = 0;
    vs_low  = 0;
    act_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst DrawX", 32'(d_x), 0);
    chk("rst blank", 32'(d_blank), 1);
    chk("rst hs", 32'(d_hs), 1);
    chk("rst line_start", 32'(d_ls), 0);
    chk("rst blank_d", 32'(d_blank_d), 0);
    chk("rst hs_d", 32'(d_hs_d), 1);
    #2 rst_n = 1'b1;

    for (int k = 1; k <= 1657; k++) begin
      @(negedge clk);
      if (k <= 800 && !d_hs) hs_low++;
      if (k <= 150 && !s_vs) vs_low++;
      if (k <= 150 && s_blank) act_cnt++;
      case (k)
        1: begin
          chk("first DrawX", 32'(d_x), 1);
          chk("first line_start", 32'(d_ls), 0);
          chk("blank_d still low", 32'(d_blank_d), 0);
        end
        2:   chk("blank_d rises", 32'(d_blank_d), 1);
        67:  chk("small last active", 32'(s_blank), 1);
        68:  chk("small after active", 32'(s_blank), 0);
        149: chk("small fc before wrap", 32'(s_fc), 0);
        150: begin
          chk("small frame_start", 32'(s_fs), 1);
          chk("small fc after wrap", 32'(s_fc), 1);
        end
        151: chk("small frame_start 1cyc", 32'(s_fs), 0);
        639: chk("blank at x639", 32'(d_blank), 1);
        640: chk("blank at x640", 32'(d_blank), 0);
        655: chk("hs at x655", 32'(d_hs), 1);
        656: chk("hs at x656", 32'(d_hs), 0);
        658: chk("hs_d at x658", 32'(d_hs_d), 0);
        751: chk("hs at x751", 32'(d_hs), 0);
        752: chk("hs at x752", 32'(d_hs), 1);
        800: begin
          chk("line_start at wrap", 32'(d_ls), 1);
          chk("DrawX wrap", 32'(d_x), 0);
          chk("DrawY step", 32'(d_y), 1);
        end
        default: ;
      endcase
    end
    chk("hs low count", 32'(hs_low), 96);
    chk("small vs low count", 32'(vs_low), 30);
    chk("small active count", 32'(act_cnt), 40);

    // Asynchronous reset between edges, mid-line.
    #2 rst_n = 1'b0;
    #1;
    chk("async DrawX", 32'(d_x), 0);
    chk("async DrawY", 32'(d_y), 0);
    chk("async hs", 32'(d_hs), 1);
    chk("async vs", 32'(d_vs), 1);
    chk("async blank", 32'(d_blank), 1);
    chk("async line_start", 32'(d_ls), 0);
    chk("async frame_count", 32'(s_fc), 0);
    chk("async hs_d", 32'(d_hs_d), 1);
    chk("async blank_d", 32'(d_blank_d), 0);
    chk("async small DrawX", 32'(s_x), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("restart DrawX", 32'(d_x), 1);
    chk("restart DrawY", 32'(d_y), 0);
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters: H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters: H_FP, 16, horizontal front porch, in pixels.
REQ-003 Parameters: H_SYNC, 96, horizontal sync width, in pixels.
REQ-004 Parameters: H_BP, 48, horizontal back porch, in pixels.
REQ-005 Parameters: V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameters: V_FP, 10, vertical front porch, in lines.
REQ-007 Parameters: V_SYNC, 2, vertical sync width, in lines.
REQ-008 Parameters: V_BP, 33, vertical back porch, in lines.
REQ-009 Parameters: PIPE_DELAY, 2, delay in cycles applied to the *_d outputs (0..7).
REQ-010 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-011 vga_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-012 reset_n  input  1  asynchronous active-low reset.
REQ-013 DrawX  output  10  current horizontal counter, 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800).
REQ-014 DrawY  output  10  current vertical counter, 0..V_TOTAL-1, where V_TOTAL = sum of the V_* parameters (525).
REQ-015 blank  output  1  high means active video: DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-016 hs, vs  output  1 each  horizontal and vertical sync, active low.
REQ-017 line_start  output  1  one-cycle pulse while DrawX==0.
REQ-018 frame_start  output  1  one-cycle pulse while DrawX==0 and DrawY==0.
REQ-019 frame_count  output  16  number of completed frames, wraps modulo 65536.
REQ-020 hs_d, vs_d, blank_d  output  1 each  hs, vs and blank delayed by PIPE_DELAY cycles, so they align with a downstream registered ROM/palette pixel path.

Function
REQ-021 The horizontal counter SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-022 The vertical counter SHALL increment only on the cycle the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-023 DrawX and DrawY SHALL be the counter registers directly.
REQ-024 blank, hs, vs, line_start and frame_start SHALL be registered and decoded from next-state counter values, so each is glitch-free and matches the DrawX/DrawY of the same cycle.
REQ-025 hs SHALL be 0 exactly for DrawX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 at defaults), on every line.
REQ-026 vs SHALL be 0 exactly for DrawY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 at defaults), for all DrawX on those lines.
REQ-027 frame_count SHALL increment by 1 on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), i.e. coincident with frame_start going high; 65535 SHALL wrap to 0.
REQ-028 The *_d outputs SHALL be a PIPE_DELAY-deep shift register; with PIPE_DELAY=0 they SHALL equal the undelayed signals combinationally.
REQ-029 All widths SHALL be unsigned; counter comparisons SHALL be computed at 10 bits without overflow for the default parameters.

Reset
REQ-030 While reset_n=0, asynchronously: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, line_start=0, frame_start=0, frame_count=0.
REQ-031 While reset_n=0, asynchronously: every stage of the *_d shift register SHALL hold hs_d=1, vs_d=1 and blank_d=0.
REQ-032 On the first edge after reset_n rises, DrawX SHALL become 1.
REQ-033 The first line_start SHALL occur at the first horizontal wrap, and the first frame_start at the first frame wrap; neither pulses at reset release.
REQ-034 Asserting reset_n mid-frame SHALL return all outputs to their reset values immediately, independent of vga_clk.

Verification
REQ-035 Release reset and run 800 cycles: DrawX steps 0..799 then 0; hs low for exactly 96 consecutive cycles starting at DrawX=656; line_start high at cycle 800.
REQ-036 Run one full frame (420000 cycles): vs low for exactly 1600 cycles starting at (0,490); blank high for exactly 307200 cycles.
REQ-037 At the frame wrap: frame_start pulses for one cycle and frame_count goes 0 -> 1; preload frame_count to 65535 and check it wraps to 0.
REQ-038 With PIPE_DELAY=2: hs_d equals hs from 2 cycles earlier on every cycle; blank_d first rises 2 cycles after reset release.
REQ-039 Assert reset_n low at (DrawX=300, DrawY=200) between clock edges: outputs take their reset values before the next edge; after release, counting restarts from (0,0).
REQ-040 Check the consumer address alignment: at DrawX=639, DrawY=479, blank=1; on the next cycle blank=0.
